// File: rtl/sort_pkg.sv
// Shared constants and FSM state type for the sort buffer and sort controller.
package sort_pkg;

  localparam int unsigned K  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StGo    = 2'd1,
    StSort  = 2'd2,
    StDrain = 2'd3
  } state_e;

  // True when the address names a real entry (matters only for non-power-of-2 K).
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return 32'(addr) < K;
  endfunction

endpackage

// File: rtl/sort_buffer_if.sv
// Host load/drain streams, sort-engine memory port and control for the sort buffer.
interface sort_buffer_if;
  import sort_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] Addr;
  logic [W-1:0]  Din;
  logic          WE;
  logic [W-1:0]  Dout;
  logic          sort_go;
  logic          sort_done;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          abort;
  logic          busy;

  modport slave (
    input  in_valid, in_data, Addr, Din, WE, sort_done, out_ready, abort,
    output in_ready, Dout, sort_go, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, Addr, Din, WE, sort_done, out_ready, abort,
    input  in_ready, Dout, sort_go, out_valid, out_data, busy
  );

endinterface

// File: rtl/sort_regfile.sv
// K x W working memory: one write port, two combinational read ports, cleared on reset.
module sort_regfile
  import sort_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [W-1:0]  rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_b_o
);

  logic [W-1:0] mem_q [K];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < K; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && addr_ok(waddr_i)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (addr_ok(raddr_a_i)) rdata_a_o = mem_q[raddr_a_i];
    if (addr_ok(raddr_b_i)) rdata_b_o = mem_q[raddr_b_i];
  end

endmodule

// File: rtl/sort_buffer.sv
// Sort buffer top: load/go/sort/drain FSM, load and drain pointers, write-port mux.
module sort_buffer
  import sort_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  sort_buffer_if.slave bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  drain_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = bus.in_data;

    if (bus.abort) begin
      // Abort beats every transition and write; memory keeps its contents.
      state_d  = StLoad;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (bus.in_valid) begin
            mem_we = 1'b1;
            if (wr_ptr_q == AW'(K - 1)) begin
              wr_ptr_d = '0;
              state_d  = StGo;
            end else begin
              wr_ptr_d = wr_ptr_q + AW'(1);
            end
          end
        end
        StGo: state_d = StSort;
        StSort: begin
          if (bus.WE) begin
            mem_we    = 1'b1;
            mem_waddr = bus.Addr;
            mem_wdata = bus.Din;
          end
          if (bus.sort_done) state_d = StDrain;
        end
        StDrain: begin
          if (bus.out_ready) begin
            if (rd_ptr_q == AW'(K - 1)) begin
              rd_ptr_d = '0;
              state_d  = StLoad;
            end else begin
              rd_ptr_d = rd_ptr_q + AW'(1);
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  sort_regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_a_i (bus.Addr),
    .rdata_a_o (bus.Dout),
    .raddr_b_i (rd_ptr_q),
    .rdata_b_o (drain_data)
  );

  always_comb begin
    bus.in_ready  = (state_q == StLoad);
    bus.sort_go   = (state_q == StGo);
    bus.out_valid = (state_q == StDrain);
    bus.busy      = (state_q != StLoad);
    bus.out_data  = bus.out_valid ? drain_data : '0;
  end

endmodule

// File: tb/tb_sort_buffer.sv
// Directed bench for sort_buffer: load, sort handoff, drain, engine writes, abort, reset.
module tb_sort_buffer;
  import sort_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sort_buffer_if bus ();

  sort_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ld1  [8] = '{8'h08, 8'h03, 8'h07, 8'h01, 8'h06, 8'h02, 8'h05, 8'h04};
  logic [7:0] ld2  [8] = '{8'h50, 8'h20, 8'h70, 8'h10, 8'h60, 8'h30, 8'h80, 8'h40};
  logic [7:0] srt2 [8] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
  logic [7:0] ld3  [8] = '{8'h18, 8'h13, 8'h17, 8'h11, 8'h16, 8'h12, 8'h15, 8'h14};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host accept; in_ready and a quiet sort_go are checked before the edge.
  task automatic load_word(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    #1;
    chk("load_ready", 32'(bus.in_ready), 32'd1);
    chk("load_no_go", 32'(bus.sort_go), 32'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic eng_wr(input logic [2:0] a, input logic [7:0] d, input logic done);
    bus.Addr      = a;
    bus.Din       = d;
    bus.WE        = 1'b1;
    bus.sort_done = done;
    tick();
    bus.WE        = 1'b0;
    bus.sort_done = 1'b0;
  endtask

  task automatic drain_all(input logic [7:0] base);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_data", 32'(bus.out_data), 32'(base + 8'(i)));
      chk("drain_not_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b0;
    #1;
    chk("drain_back_load", 32'(bus.in_ready), 32'd1);
    chk("drain_valid_low", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int idx;
    int cyc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.Addr      = '0;
    bus.Din       = '0;
    bus.WE        = 1'b0;
    bus.sort_done = 1'b0;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset and idle
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sort_go", 32'(bus.sort_go), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus.Addr = 3'(a);
      #1;
      chk("rst_dout", 32'(bus.Dout), 32'd0);
    end
    tick();

    // Round 1: load, go pulse, model engine writes 1..8, drain
    for (int i = 0; i < 8; i++) load_word(ld1[i]);
    bus.Addr = 3'd3;
    #1;
    chk("go_pulse", 32'(bus.sort_go), 32'd1);
    chk("go_in_ready", 32'(bus.in_ready), 32'd0);
    chk("go_busy", 32'(bus.busy), 32'd1);
    chk("load_dout3", 32'(bus.Dout), 32'h01);
    tick();
    chk("sort_go_low", 32'(bus.sort_go), 32'd0);
    chk("sort_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) eng_wr(3'(i), 8'(i + 1), 1'b0);
    #1;
    chk("sort_no_valid", 32'(bus.out_valid), 32'd0);
    bus.sort_done = 1'b1;
    tick();
    bus.sort_done = 1'b0;
    drain_all(8'h01);

    // Engine write and sort_done ignored in LOAD
    bus.Addr      = 3'd2;
    bus.Din       = 8'hAA;
    bus.WE        = 1'b1;
    bus.sort_done = 1'b1;
    tick();
    bus.WE        = 1'b0;
    bus.sort_done = 1'b0;
    #1;
    chk("we_in_load", 32'(bus.Dout), 32'h03);
    chk("done_in_load", 32'(bus.busy), 32'd0);

    // Round 2: engine write during SORT, write with sort_done, write ignored in DRAIN, stalls
    for (int i = 0; i < 8; i++) load_word(ld2[i]);
    tick();
    eng_wr(3'd2, 8'hAA, 1'b0);
    bus.Addr = 3'd2;
    #1;
    chk("we_in_sort", 32'(bus.Dout), 32'hAA);
    for (int i = 0; i < 7; i++) eng_wr(3'(i), srt2[i], 1'b0);
    eng_wr(3'd7, 8'h80, 1'b1);
    bus.Addr = 3'd7;
    #1;
    chk("we_with_done", 32'(bus.Dout), 32'h80);
    chk("drain_entered", 32'(bus.out_valid), 32'd1);
    bus.Addr = 3'd2;
    bus.Din  = 8'hAA;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
    #1;
    chk("we_in_drain", 32'(bus.Dout), 32'h30);
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 40) begin
      bus.out_ready = (cyc % 3 == 0);
      #1;
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_data", 32'(bus.out_data), 32'(srt2[idx]));
      if (bus.out_ready) idx++;
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("stall_word_count", 32'(idx), 32'd8);
    chk("stall_back_load", 32'(bus.in_ready), 32'd1);

    // Abort after five loads, then a full fresh load and sort
    for (int i = 0; i < 5; i++) load_word(8'hF1 + 8'(i));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.Addr  = 3'd0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_mem_kept", 32'(bus.Dout), 32'hF1);
    for (int i = 0; i < 8; i++) load_word(ld3[i]);
    #1;
    chk("abort_go", 32'(bus.sort_go), 32'd1);
    chk("abort_wr_ptr0", 32'(bus.Dout), 32'h18);
    tick();
    for (int i = 0; i < 8; i++) eng_wr(3'(i), 8'h11 + 8'(i), 1'b0);
    bus.sort_done = 1'b1;
    tick();
    bus.sort_done = 1'b0;
    drain_all(8'h11);

    // Async reset asserted mid-SORT
    for (int i = 0; i < 8; i++) load_word(8'h99);
    tick();
    eng_wr(3'd2, 8'h55, 1'b0);
    bus.Addr = 3'd2;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_sort_go", 32'(bus.sort_go), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data", 32'(bus.out_data), 32'd0);
    chk("arst_dout", 32'(bus.Dout), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
